// File: rtl/flexbex_efpga_offload_ctrl.sv
// eFPGA offload controller: captures one custom-instruction request, launches it on the fabric,
// and returns the selected result after a fixed delay or a done handshake with timeout.
module flexbex_efpga_offload_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned OP_W           = 2,
  parameter int unsigned NUM_RESULTS    = 3,
  parameter int unsigned DELAY_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [OP_W-1:0]             operator_i,
  input  logic [DATA_W-1:0]           operand_a_i,
  input  logic [DATA_W-1:0]           operand_b_i,
  input  logic [DELAY_W-1:0]          delay_i,
  output logic                        ready_o,
  output logic [DATA_W-1:0]           result_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            op_cnt_o,
  output logic [DATA_W-1:0]           efpga_operand_a_o,
  output logic [DATA_W-1:0]           efpga_operand_b_o,
  output logic [OP_W-1:0]             efpga_operator_o,
  output logic                        efpga_write_strobe_o,
  input  logic                        efpga_done_i,
  input  logic [NUM_RESULTS*DATA_W-1:0] efpga_results_i
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [OP_W-1:0]     oper_q;
  logic [DELAY_W-1:0]  delay_q, dcnt_q;
  logic [TimerW-1:0]   timer_q;
  logic [DATA_W-1:0]   result_q;
  logic                err_q;
  logic [CNT_W-1:0]    op_cnt_q;

  logic                legal_op;
  logic                fixed_mode;
  logic                last_fixed;
  logic                timeout;
  logic [DATA_W-1:0]   sel_result;

  assign legal_op   = 32'(operator_i) < NUM_RESULTS;
  assign fixed_mode = delay_q != '0;
  assign last_fixed = dcnt_q == DELAY_W'(1);
  assign timeout    = timer_q == TimerW'(TIMEOUT_CYCLES - 1);

  // Only legal operators are ever latched, so oper_q always names an existing channel.
  always_comb begin
    sel_result = '0;
    for (int k = 0; k < int'(NUM_RESULTS); k++) begin
      if (oper_q == OP_W'(k)) begin
        sel_result = efpga_results_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = legal_op ? StIssue : StDone;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (fixed_mode) begin
          if (last_fixed) begin
            state_d = StDone;
          end
        end else if (efpga_done_i || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opa_q    <= '0;
      opb_q    <= '0;
      oper_q   <= '0;
      delay_q  <= '0;
      dcnt_q   <= '0;
      timer_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i) begin
            result_q <= '0;
            err_q    <= ~legal_op;
            if (legal_op) begin
              opa_q   <= operand_a_i;
              opb_q   <= operand_b_i;
              oper_q  <= operator_i;
              delay_q <= delay_i;
            end
          end
        end
        StIssue: begin
          dcnt_q  <= delay_q;
          timer_q <= '0;
        end
        StWait: begin
          if (fixed_mode) begin
            dcnt_q <= dcnt_q - DELAY_W'(1);
            if (last_fixed) begin
              result_q <= sel_result;
              err_q    <= 1'b0;
            end
          end else if (efpga_done_i) begin
            // Done wins over a coincident timeout.
            result_q <= sel_result;
            err_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
            if (timeout) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        StDone: op_cnt_q <= op_cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ready_o              = 1'b0;
    result_o             = '0;
    err_o                = 1'b0;
    busy_o               = state_q != StIdle;
    efpga_write_strobe_o = 1'b0;
    unique case (state_q)
      StIssue: efpga_write_strobe_o = 1'b1;
      StDone: begin
        ready_o  = 1'b1;
        result_o = result_q;
        err_o    = err_q;
      end
      default: ;
    endcase
  end

  assign op_cnt_o          = op_cnt_q;
  assign efpga_operand_a_o = opa_q;
  assign efpga_operand_b_o = opb_q;
  assign efpga_operator_o  = oper_q;

endmodule
